// File: rtl/led_pkg.sv
// Shared constants and state encoding for the LED PWM stage.
package led_pkg;

    localparam int unsigned PWM_BITS = 5;
    localparam int unsigned PWM_LAST = 30;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STARVED = 2'd2
    } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small circular sample buffer with push/pop handshake and asynchronous reset.
module sample_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/led_pwm_stage.sv
// Buffered brightness samples displayed as a 31-tick PWM waveform on one LED,
// each sample held for HOLD_PERIODS periods; duty only changes on period boundaries.
module led_pwm_stage
    import led_pkg::*;
#(
    parameter int unsigned HOLD_PERIODS = 4,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                TICK,
    input  logic                in_valid,
    input  logic [PWM_BITS-1:0] in_data,
    output logic                in_ready,
    output logic                LED,
    output logic                busy,
    output logic                underrun
);

    state_t              state;
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] cnt_next;
    logic [PWM_BITS-1:0] duty;
    logic [7:0]          hold;
    logic                ready_en;
    logic                led_q;
    logic                busy_q;
    logic                underrun_q;

    logic                push;
    logic                pop;
    logic [PWM_BITS-1:0] head;
    logic                full;
    logic                empty;
    logic                boundary;
    logic                hold_done;

    // ready_en keeps in_ready low while reset is held and until the first edge after release
    assign in_ready  = ready_en & ~full;
    assign push      = in_valid & in_ready;
    assign boundary  = TICK && (cnt == PWM_BITS'(PWM_LAST));
    assign hold_done = ((hold + 8'd1) == 8'(HOLD_PERIODS));
    assign cnt_next  = !TICK ? cnt : (cnt == PWM_BITS'(PWM_LAST)) ? '0 : cnt + PWM_BITS'(1);

    assign LED      = led_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PWM_BITS)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !empty;
            RUN:     pop = boundary && hold_done && !empty;
            STARVED: pop = boundary && !empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            duty       <= '0;
            hold       <= '0;
            ready_en   <= 1'b0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            led_q    <= (state != IDLE) && (cnt < duty);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!empty) begin
                        duty   <= head;
                        hold   <= '0;
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt_next;
                    if (boundary) begin
                        if (!hold_done) begin
                            hold <= hold + 8'd1;
                        end else if (!empty) begin
                            duty <= head;
                            hold <= '0;
                        end else begin
                            state      <= STARVED;
                            busy_q     <= 1'b0;
                            underrun_q <= 1'b1;
                        end
                    end
                end
                STARVED: begin
                    cnt <= cnt_next;
                    if (boundary && !empty) begin
                        duty   <= head;
                        hold   <= '0;
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pwm_stage.sv
// Randomized bench comparing the PWM stage against a queue-based behavioural model.
module tb_led_pwm_stage;

    localparam int HOLD = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       TICK = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] in_data = '0;
    logic       in_ready;
    logic       LED;
    logic       busy;
    logic       underrun;

    int errors = 0;
    int checks = 0;

    led_pwm_stage #(
        .HOLD_PERIODS (HOLD),
        .FIFO_DEPTH   (2)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .TICK     (TICK),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .LED      (LED),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 CLK = ~CLK;

    // behavioural model: waiting words, what is on display, and the PWM phase
    int q[$];
    bit showing;
    bit starved;
    int cnt;
    int duty;
    int held;
    bit ready_en;
    bit led_e;
    bit urun;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        q.delete();
        showing  = 0;
        starved  = 0;
        cnt      = 0;
        duty     = 0;
        held     = 0;
        ready_en = 0;
        led_e    = 0;
        urun     = 0;
    endfunction

    function automatic void model_step();
        bit rdy    = ready_en && (q.size() < 2);
        bit pushed = in_valid && rdy;
        bit have   = (q.size() > 0);
        bit led_n  = (showing || starved) && (cnt < duty);
        bit wrap   = TICK && (cnt == 30);
        if (!showing && !starved) begin
            if (have) begin
                duty    = q.pop_front();
                held    = 0;
                cnt     = 0;
                showing = 1;
            end
        end else begin
            if (TICK) cnt = (cnt + 1) % 31;
            if (wrap) begin
                if (showing) begin
                    held++;
                    if (held == HOLD) begin
                        if (have) begin
                            duty = q.pop_front();
                            held = 0;
                        end else begin
                            showing = 0;
                            starved = 1;
                            urun    = 1;
                        end
                    end
                end else if (have) begin
                    duty    = q.pop_front();
                    held    = 0;
                    starved = 0;
                    showing = 1;
                end
            end
        end
        if (pushed) q.push_back(int'(in_data));
        ready_en = 1;
        led_e    = led_n;
    endfunction

    task automatic check_outputs();
        chk("in_ready", in_ready, ready_en && (q.size() < 2));
        chk("LED", LED, led_e);
        chk("busy", busy, showing);
        chk("underrun", underrun, urun);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_LED"}, LED, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
    endtask

    // assert reset between edges and confirm outputs clear without a clock
    task automatic do_reset();
        RESET = 1'b1;
        #1;
        check_reset_state("rst_async");
        model_clear();
        in_valid = 1'b0;
        TICK     = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check_reset_state("rst_held");
        RESET = 1'b0;
    endtask

    task automatic drive(input int phase);
        case (phase)
            0: begin
                TICK     = 1'b1;
                in_valid = ($urandom_range(99) < 30);
                case ($urandom_range(2))
                    0:       in_data = 5'd0;
                    1:       in_data = 5'd31;
                    default: in_data = 5'd16;
                endcase
            end
            1: begin
                TICK     = 1'b1;
                in_valid = 1'b1;
                in_data  = 5'($urandom_range(31));
            end
            2: begin
                TICK     = ($urandom_range(2) == 0);
                in_valid = ($urandom_range(99) < 2);
                in_data  = 5'($urandom_range(31));
            end
            default: begin
                TICK     = ($urandom_range(3) != 0);
                in_valid = ($urandom_range(99) < 5);
                in_data  = 5'($urandom_range(31));
            end
        endcase
    endtask

    initial begin
        int len [5] = '{800, 400, 3000, 1500, 1500};
        model_clear();
        #1;
        check_reset_state("rst_init");
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        drive(0);
        for (int p = 0; p < 5; p++) begin
            for (int n = 0; n < len[p]; n++) begin
                @(posedge CLK);
                model_step();
                @(negedge CLK);
                check_outputs();
                if (p == 1 && n == len[p] - 1) begin
                    chk("full_before_reset", q.size(), 2);
                    do_reset();
                end else if (p >= 3 && $urandom_range(799) == 0) begin
                    do_reset();
                end
                drive(p);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
